// File: rtl/sum_accum.sv
// Frame accumulator: sums a programmable number of input words with saturation and
// queues each frame total in a 2-entry output FIFO that drops frames when full.
module sum_accum #(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic             in_valid_i,
  input  logic [LEN_W-1:0] frame_len_i,
  input  logic             clr_i,
  output logic [ACC_W-1:0] acc_data_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             acc_sat_o,
  output logic             overflow_o,
  output logic [7:0]       drop_cnt_o
);

  localparam int unsigned CntW = LEN_W + 1;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             sat_q, sat_d;

  logic             push;
  logic [ACC_W-1:0] push_acc;
  logic             push_sat;

  logic [ACC_W-1:0] in_ext;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_sum;
  logic             sat_sum;
  logic [CntW-1:0]  cnt_inc;

  // A programmed length of zero stands for the full 2^LEN_W samples.
  function automatic logic [CntW-1:0] resolve_len(input logic [LEN_W-1:0] len);
    if (len == '0) begin
      return {1'b1, {LEN_W{1'b0}}};
    end
    return {1'b0, len};
  endfunction

  assign in_ext   = ACC_W'(in_data_i);
  assign sum_wide = {1'b0, acc_q} + {1'b0, in_ext};
  assign acc_sum  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign sat_sum  = sat_q | sum_wide[ACC_W];
  assign cnt_inc  = cnt_q + CntW'(1);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    sat_d    = sat_q;
    push     = 1'b0;
    push_acc = acc_q;
    push_sat = sat_q;
    if (clr_i) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (in_valid_i) begin
      unique case (state_q)
        StIdle: begin
          len_d = frame_len_i;
          if (resolve_len(frame_len_i) == CntW'(1)) begin
            push     = 1'b1;
            push_acc = in_ext;
            push_sat = 1'b0;
            acc_d    = '0;
            cnt_d    = '0;
            sat_d    = 1'b0;
          end else begin
            state_d = StAccum;
            acc_d   = in_ext;
            cnt_d   = CntW'(1);
            sat_d   = 1'b0;
          end
        end
        StAccum: begin
          if (cnt_inc == resolve_len(len_q)) begin
            push     = 1'b1;
            push_acc = acc_sum;
            push_sat = sat_sum;
            state_d  = StIdle;
            acc_d    = '0;
            cnt_d    = '0;
            sat_d    = 1'b0;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
            sat_d = sat_sum;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
    end
  end

  // Output FIFO: each entry holds {sat, acc}.
  logic [1:0][ACC_W:0] mem_q;
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          count_q;
  logic                overflow_q;
  logic [7:0]          drop_cnt_q;
  logic                pop, full, do_push, drop;

  assign pop     = acc_valid_o & acc_ready_i;
  assign full    = (count_q == 2'd2);
  // When full, a simultaneous pop frees the slot the write pointer already targets.
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= {push_sat, push_acc};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
    end
  end

  assign acc_valid_o = (count_q != 2'd0);
  assign acc_data_o  = mem_q[rd_ptr_q][ACC_W-1:0];
  assign acc_sat_o   = mem_q[rd_ptr_q][ACC_W];
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum: two instances (ACC_W=16 and ACC_W=12) share all inputs.
module tb_sum_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  frame_len = 4'd4;
  logic        clr = 1'b0;
  logic        acc_ready = 1'b1;

  logic [15:0] a16_data;
  logic        a16_valid, a16_sat, a16_ovf;
  logic [7:0]  a16_drop;
  logic [11:0] a12_data;
  logic        a12_valid, a12_sat, a12_ovf;
  logic [7:0]  a12_drop;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sum_accum #(.IN_W(10), .ACC_W(16), .LEN_W(4)) u16 (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .frame_len_i(frame_len), .clr_i(clr), .acc_data_o(a16_data), .acc_valid_o(a16_valid),
    .acc_ready_i(acc_ready), .acc_sat_o(a16_sat), .overflow_o(a16_ovf), .drop_cnt_o(a16_drop)
  );

  sum_accum #(.IN_W(10), .ACC_W(12), .LEN_W(4)) u12 (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .frame_len_i(frame_len), .clr_i(clr), .acc_data_o(a12_data), .acc_valid_o(a12_valid),
    .acc_ready_i(acc_ready), .acc_sat_o(a12_sat), .overflow_o(a12_ovf), .drop_cnt_o(a12_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 10'(v);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(a16_valid), 32'd0);
    chk("rst_data", 32'(a16_data), 32'd0);
    chk("rst_sat", 32'(a16_sat), 32'd0);
    chk("rst_ovf", 32'(a16_ovf), 32'd0);
    chk("rst_drop", 32'(a16_drop), 32'd0);
    rst_n = 1'b1;
    tick();

    // Four-sample frame, single-cycle result
    frame_len = 4'd4;
    acc_ready = 1'b1;
    send(10);
    chk("f4_v1", 32'(a16_valid), 32'd0);
    send(20);
    chk("f4_v2", 32'(a16_valid), 32'd0);
    send(30);
    chk("f4_v3", 32'(a16_valid), 32'd0);
    send(40);
    chk("f4_valid", 32'(a16_valid), 32'd1);
    chk("f4_data", 32'(a16_data), 32'd100);
    chk("f4_sat", 32'(a16_sat), 32'd0);
    tick();
    chk("f4_valid_gone", 32'(a16_valid), 32'd0);

    // 16-sample frame of max words; saturates only in the narrow instance
    frame_len = 4'd0;
    for (int i = 0; i < 16; i++) begin
      send(10'h3FF);
      if (i == 14) chk("f16_not_yet", 32'(a16_valid), 32'd0);
    end
    chk("f16_valid", 32'(a16_valid), 32'd1);
    chk("f16_data", 32'(a16_data), 32'd16368);
    chk("f16_sat", 32'(a16_sat), 32'd0);
    chk("f12_valid", 32'(a12_valid), 32'd1);
    chk("f12_data", 32'(a12_data), 32'd4095);
    chk("f12_sat", 32'(a12_sat), 32'd1);
    tick();

    // Length-1 frames with a stalled sink: third result is dropped
    frame_len = 4'd1;
    acc_ready = 1'b0;
    send(5);
    chk("l1_head5", 32'(a16_data), 32'd5);
    send(6);
    chk("l1_hold5", 32'(a16_data), 32'd5);
    send(7);
    chk("l1_ovf", 32'(a16_ovf), 32'd1);
    chk("l1_drop", 32'(a16_drop), 32'd1);
    chk("l1_head_still5", 32'(a16_data), 32'd5);
    for (int i = 0; i < 260; i++) send(i & 10'h3FF);
    chk("drop_sat", 32'(a16_drop), 32'd255);
    chk("drop_head5", 32'(a16_data), 32'd5);
    acc_ready = 1'b1;
    tick();
    chk("drain_6", 32'(a16_data), 32'd6);
    chk("drain_6_valid", 32'(a16_valid), 32'd1);
    tick();
    chk("drain_empty", 32'(a16_valid), 32'd0);

    // clr aborts a partial frame; frame_len change mid-frame is ignored
    frame_len = 4'd3;
    send(1);
    send(2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_no3", 32'(a16_valid), 32'd0);
    send(4);
    frame_len = 4'd1;
    chk("clr_v4", 32'(a16_valid), 32'd0);
    send(5);
    chk("clr_v5", 32'(a16_valid), 32'd0);
    send(6);
    chk("clr_valid", 32'(a16_valid), 32'd1);
    chk("clr_data", 32'(a16_data), 32'd15);
    tick();
    chk("clr_empty", 32'(a16_valid), 32'd0);

    // clr with the closing sample cancels the push
    frame_len = 4'd2;
    send(1);
    clr = 1'b1;
    send(2);
    clr = 1'b0;
    chk("clr_close_nopush", 32'(a16_valid), 32'd0);
    send(3);
    send(4);
    chk("after_clr_data", 32'(a16_data), 32'd7);
    tick();

    // Fresh reset clears the sticky overflow
    rst_n = 1'b0;
    #1;
    chk("rst2_ovf", 32'(a16_ovf), 32'd0);
    chk("rst2_drop", 32'(a16_drop), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full FIFO with push and pop on the same edge: no drop, order kept
    frame_len = 4'd1;
    acc_ready = 1'b0;
    send(11);
    send(12);
    acc_ready = 1'b1;
    send(13);
    chk("pp_head12", 32'(a16_data), 32'd12);
    chk("pp_ovf", 32'(a16_ovf), 32'd0);
    chk("pp_drop", 32'(a16_drop), 32'd0);
    tick();
    chk("pp_head13", 32'(a16_data), 32'd13);
    chk("pp_valid13", 32'(a16_valid), 32'd1);
    tick();
    chk("pp_empty", 32'(a16_valid), 32'd0);

    // One entry plus push and pop: new result at the head
    acc_ready = 1'b0;
    send(21);
    acc_ready = 1'b1;
    send(22);
    chk("one_pp_head", 32'(a16_data), 32'd22);
    tick();
    chk("one_pp_empty", 32'(a16_valid), 32'd0);

    // Reset mid-frame with one queued entry
    acc_ready = 1'b0;
    send(9);
    frame_len = 4'd3;
    send(1);
    send(2);
    chk("pre_rst_valid", 32'(a16_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst3_valid", 32'(a16_valid), 32'd0);
    chk("rst3_drop", 32'(a16_drop), 32'd0);
    chk("rst3_data", 32'(a16_data), 32'd0);
    tick();
    rst_n = 1'b1;
    acc_ready = 1'b1;
    tick();
    chk("rst3_nopush", 32'(a16_valid), 32'd0);
    frame_len = 4'd2;
    send(3);
    chk("rst3_v3", 32'(a16_valid), 32'd0);
    send(4);
    chk("rst3_valid7", 32'(a16_valid), 32'd1);
    chk("rst3_data7", 32'(a16_data), 32'd7);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 Parameter IN_W, default 10, width of each incoming sum word.
REQ-002 Parameter ACC_W, default 16, width of the accumulated result.
REQ-003 Parameter LEN_W, default 4, width of the frame-length control.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 in_data  input  IN_W  unsigned sum word from the upstream adder stage.
REQ-007 in_valid  input  1  in_data valid this cycle; no backpressure to upstream exists.
REQ-008 frame_len  input  LEN_W  samples per frame; value 0 means 2^LEN_W.
REQ-009 clr  input  1  synchronous abort of the partial frame.
REQ-010 acc_data  output  ACC_W  accumulated frame total at the output FIFO head.
REQ-011 acc_valid  output  1  acc_data valid (FIFO not empty).
REQ-012 acc_ready  input  1  downstream accepts acc_data this cycle.
REQ-013 acc_sat  output  1  the head result saturated during accumulation.
REQ-014 overflow  output  1  sticky: at least one completed frame was dropped.
REQ-015 drop_cnt  output  8  count of dropped frames, saturating at 255.

Function
REQ-016 Two-state FSM shall be used: IDLE (no partial frame) and ACCUM (partial frame open).
REQ-017 In IDLE, in_valid shall load acc <= zero-extended in_data, cnt <= 1, latch frame_len into len_q, and go to ACCUM, unless len_q resolves to 1, which closes the frame at once and stays in IDLE.
REQ-018 In ACCUM, each in_valid shall add in_data to acc and increment cnt; when cnt reaches len_q, the frame closes and the FSM returns to IDLE.
REQ-019 frame_len changes mid-frame shall not affect the open frame, which uses len_q only.
REQ-020 Accumulation shall saturate at 2^ACC_W-1, and any saturation within a frame shall set that frame's sat bit.
REQ-021 A closing frame shall push {sat, acc} into a 2-entry FIFO on the same edge as the last sample.
REQ-022 acc_valid shall therefore be high in the cycle immediately after the final sample's edge, giving 1-cycle latency when the FIFO was empty.
REQ-023 A FIFO pop shall occur on an edge with acc_valid and acc_ready both high.
REQ-024 acc_data and acc_sat shall remain stable while acc_valid is high and acc_ready is low.
REQ-025 A push with the FIFO full and no pop on the same edge shall drop the frame, set overflow, and increment drop_cnt (saturating); FIFO contents shall be unchanged.
REQ-026 A push and a pop on the same edge with the FIFO full shall both succeed, with no drop.
REQ-027 A push and a pop on the same edge with one entry shall leave occupancy at 1, with the new result at the head.
REQ-028 clr shall return the FSM to IDLE, zero acc, cnt and sat, and discard the partial frame; the FIFO, overflow and drop_cnt shall not change.
REQ-029 clr together with in_valid shall discard that sample.
REQ-030 clr on the edge where a frame would close shall cancel the push.
REQ-031 in_valid low shall leave acc, cnt and the FSM unchanged.

Reset
REQ-032 On rst_n low, the following shall clear asynchronously: FSM to IDLE; acc, cnt, len_q and FIFO pointers to 0; acc_valid, acc_sat and overflow to 0; drop_cnt to 0.
REQ-033 acc_data shall read 0 while reset is active.
REQ-034 Reset asserted mid-frame or with the FIFO occupied shall discard all data, with no push on release.
REQ-035 After rst_n rises, the first in_valid shall be treated as the first sample of a new frame.

Verification
REQ-036 frame_len=4, inputs 10,20,30,40 on consecutive cycles, acc_ready=1 -> acc_data=100 with acc_valid high for exactly 1 cycle after the 4th input; acc_sat=0.
REQ-037 frame_len=0, 16 inputs of 0x3FF, ACC_W=16 -> acc_data=16368, acc_sat=0; repeat with ACC_W=12 -> acc_data=4095, acc_sat=1.
REQ-038 frame_len=1, acc_ready=0, inputs 5,6,7 -> FIFO holds 5 then 6; 7 is dropped; overflow=1; drop_cnt=1; after raising acc_ready, outputs are 5 then 6.
REQ-039 frame_len=3, inputs 1,2 then clr, then inputs 4,5,6 -> single result 15; no result 3 ever appears.
REQ-040 FIFO full with acc_ready=1 on the same edge as a frame close -> no drop, overflow stays 0, results appear in order.
REQ-041 rst_n pulsed low mid-frame with one FIFO entry -> acc_valid=0 and drop_cnt=0 immediately; the next frame_len=2 inputs 3,4 -> acc_data=7.
